// File: rtl/unit_n_to_m.sv
// N-to-M switching unit with a 1-bit learned control weight.
// Routes fin to fout, bin back to bout, and toggles the weight on gradient.
module unit_n_to_m #(
   parameter int N_IN   = 3,
   parameter int N_OUT  = 2,
   parameter int ACC_W  = 4,
   parameter int THRESH = 8,
   parameter bit DECAY  = 1'b0,
   parameter bit INIT_W = 1'b0
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             fd_prop,
   input  logic             bk_prop,
   input  logic [N_IN-1:0]  fin,
   input  logic [N_OUT-1:0] bin,
   input  logic             wload,
   input  logic             wdata,
   output logic [N_OUT-1:0] fout,
   output logic [N_IN-1:0]  bout,
   output logic             fvalid,
   output logic             bvalid,
   output logic             control_out,
   output logic [ACC_W-1:0] acc_out
);

   localparam logic [ACC_W:0] THR = THRESH[ACC_W:0];

   // Bit j set when forward output j draws from input i under weight c.
   function automatic logic [N_OUT-1:0] src_mask(input int i, input bit c);
      logic [N_OUT-1:0] m;
      m = '0;
      for (int j = 0; j < N_OUT; j++) begin
         if (c) m[j] = (((j + 1) % N_IN) == i);
         else   m[j] = (j == i);
      end
      return m;
   endfunction

   logic             ctrl;
   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   acc_inc;
   logic [N_OUT-1:0] fwd_nxt;
   logic [N_IN-1:0]  bwd_nxt;
   logic [N_OUT-1:0] diff;
   logic             grad;

   for (genvar j = 0; j < N_OUT; j++) begin : g_fwd
      localparam int NX = (j + 1) % N_IN;
      assign fwd_nxt[j] = ctrl ? fin[NX] : fin[j];
      assign diff[j]    = bin[j] & (fin[j] ^ fin[NX]);
   end

   for (genvar i = 0; i < N_IN; i++) begin : g_bwd
      localparam logic [N_OUT-1:0] M0 = src_mask(i, 1'b0);
      localparam logic [N_OUT-1:0] M1 = src_mask(i, 1'b1);
      assign bwd_nxt[i] = ctrl ? |(bin & M1) : |(bin & M0);
   end

   assign grad    = |diff;
   assign acc_inc = {1'b0, acc} + 1'b1;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         fout   <= '0;
         bout   <= '0;
         fvalid <= 1'b0;
         bvalid <= 1'b0;
         acc    <= '0;
         ctrl   <= INIT_W;
      end else begin
         fvalid <= fd_prop;
         bvalid <= bk_prop;
         if (fd_prop) fout <= fwd_nxt;
         if (bk_prop) bout <= bwd_nxt;
         if (wload) begin
            ctrl <= wdata;
            acc  <= '0;
         end else if (bk_prop) begin
            if (grad) begin
               if (acc_inc >= THR) begin
                  acc  <= '0;
                  ctrl <= ~ctrl;
               end else begin
                  acc <= acc_inc[ACC_W-1:0];
               end
            end else if (DECAY && acc != '0) begin
               acc <= acc - 1'b1;
            end
         end
      end
   end

   assign control_out = ctrl;
   assign acc_out     = acc;

endmodule

// File: tb/tb_unit_n_to_m.sv
// Scoreboard bench for unit_n_to_m (defaults, plus a DECAY=1 instance).
// Forward/backward results are queued at drive time and popped on valid.
module tb_unit_n_to_m;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic       fd_prop, bk_prop, wload, wdata;
   logic [2:0] fin;
   logic [1:0] bin;
   logic [1:0] fout, fout_d;
   logic [2:0] bout, bout_d;
   logic       fvalid, bvalid, ctl, fvalid_d, bvalid_d, ctl_d;
   logic [3:0] acc, acc_d;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   logic [1:0] fq[$];
   logic [2:0] bq[$];
   logic [3:0] ma[2];
   logic       mc[2];

   always #5 clk_in = ~clk_in;

   unit_n_to_m u_dut (
      .clk_in(clk_in), .rst_in(rst_in), .fd_prop(fd_prop),
      .bk_prop(bk_prop), .fin(fin), .bin(bin), .wload(wload),
      .wdata(wdata), .fout(fout), .bout(bout), .fvalid(fvalid),
      .bvalid(bvalid), .control_out(ctl), .acc_out(acc)
   );

   unit_n_to_m #(.DECAY(1'b1)) u_dec (
      .clk_in(clk_in), .rst_in(rst_in), .fd_prop(fd_prop),
      .bk_prop(bk_prop), .fin(fin), .bin(bin), .wload(wload),
      .wdata(wdata), .fout(fout_d), .bout(bout_d), .fvalid(fvalid_d),
      .bvalid(bvalid_d), .control_out(ctl_d), .acc_out(acc_d)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] f_exp(input logic [2:0] f, input logic c);
      return c ? {f[2], f[1]} : {f[1], f[0]};
   endfunction

   function automatic logic [2:0] b_exp(input logic [1:0] b, input logic c);
      return c ? {b[1], b[0], 1'b0} : {1'b0, b[1], b[0]};
   endfunction

   task automatic drive(input logic fd, input logic bk, input logic wl,
                        input logic wd, input logic [2:0] f,
                        input logic [1:0] b);
      logic       g;
      logic [3:0] na[2];
      logic       nc[2];
      logic [1:0] pf;
      logic [2:0] pb;
      @(negedge clk_in);
      fd_prop = fd; bk_prop = bk; wload = wl; wdata = wd; fin = f; bin = b;
      g  = (b[0] & (f[0] ^ f[1])) | (b[1] & (f[1] ^ f[2]));
      pf = f_exp(f, mc[0]);
      pb = b_exp(b, mc[0]);
      for (int d = 0; d < 2; d++) begin
         na[d] = ma[d];
         nc[d] = mc[d];
         if (wl) begin
            na[d] = 4'd0;
            nc[d] = wd;
         end else if (bk) begin
            if (g) begin
               if (ma[d] == 4'd7) begin
                  na[d] = 4'd0;
                  nc[d] = ~mc[d];
               end else begin
                  na[d] = ma[d] + 4'd1;
               end
            end else if (d == 1 && ma[d] != 4'd0) begin
               na[d] = ma[d] - 4'd1;
            end
         end
      end
      @(posedge clk_in);
      #1;
      if (fd) fq.push_back(pf);
      if (bk) bq.push_back(pb);
      ma = na;
      mc = nc;
      fd_prop = 1'b0; bk_prop = 1'b0; wload = 1'b0;
   endtask

   always @(negedge clk_in) begin
      if (mon_en && rst_in) begin
         chk("fvalid", {31'd0, fvalid}, {31'd0, fq.size() != 0});
         chk("bvalid", {31'd0, bvalid}, {31'd0, bq.size() != 0});
         if (fvalid && fq.size() != 0) chk("fout", {30'd0, fout}, {30'd0, fq.pop_front()});
         if (bvalid && bq.size() != 0) chk("bout", {29'd0, bout}, {29'd0, bq.pop_front()});
         chk("acc", {28'd0, acc}, {28'd0, ma[0]});
         chk("ctrl", {31'd0, ctl}, {31'd0, mc[0]});
         chk("acc_dec", {28'd0, acc_d}, {28'd0, ma[1]});
         chk("ctrl_dec", {31'd0, ctl_d}, {31'd0, mc[1]});
      end
   end

   initial begin
      rst_in = 1'b1;
      fd_prop = 1'b0; bk_prop = 1'b0; wload = 1'b0; wdata = 1'b0;
      fin = '0; bin = '0;
      ma[0] = 4'd0; ma[1] = 4'd0; mc[0] = 1'b0; mc[1] = 1'b0;
      #2 rst_in = 1'b0;
      #1;
      chk("rst_fout", {30'd0, fout}, 32'd0);
      chk("rst_bout", {29'd0, bout}, 32'd0);
      chk("rst_fv", {31'd0, fvalid}, 32'd0);
      chk("rst_acc", {28'd0, acc}, 32'd0);
      chk("rst_ctrl", {31'd0, ctl}, 32'd0);
      // strobes while reset is held must be discarded
      fd_prop = 1'b1; bk_prop = 1'b1; fin = 3'b111; bin = 2'b11;
      @(posedge clk_in);
      #1;
      chk("rst_strobe_fv", {31'd0, fvalid}, 32'd0);
      chk("rst_strobe_bout", {29'd0, bout}, 32'd0);
      fd_prop = 1'b0; bk_prop = 1'b0;
      @(negedge clk_in);
      rst_in = 1'b1;
      mon_en = 1'b1;

      drive(1, 0, 0, 0, 3'b110, 2'b00);
      chk("fwd_c0", {30'd0, fout}, 32'h2);
      drive(0, 0, 0, 0, 3'b000, 2'b00);
      chk("fv_pulse", {31'd0, fvalid}, 32'd0);

      drive(0, 0, 1, 1, 3'b000, 2'b00);
      chk("wload1", {31'd0, ctl}, 32'd1);
      drive(1, 0, 0, 0, 3'b110, 2'b00);
      chk("fwd_c1", {30'd0, fout}, 32'h3);
      drive(0, 1, 0, 0, 3'b110, 2'b01);
      chk("bwd_c1", {29'd0, bout}, 32'h2);

      drive(0, 0, 1, 0, 3'b000, 2'b00);
      for (int k = 0; k < 8; k++) drive(0, 1, 0, 0, 3'b001, 2'b01);
      chk("thr_acc", {28'd0, acc}, 32'd0);
      chk("thr_ctrl", {31'd0, ctl}, 32'd1);

      // wload wins over the threshold toggle
      for (int k = 0; k < 7; k++) drive(0, 1, 0, 0, 3'b001, 2'b01);
      chk("pre_acc7", {28'd0, acc}, 32'd7);
      drive(0, 1, 1, 0, 3'b001, 2'b11);
      chk("wl_pri_ctrl", {31'd0, ctl}, 32'd0);
      chk("wl_pri_acc", {28'd0, acc}, 32'd0);

      drive(0, 1, 0, 0, 3'b000, 2'b00);
      chk("dec_hold0", {28'd0, acc_d}, 32'd0);
      drive(0, 1, 0, 0, 3'b001, 2'b01);
      chk("dec_up", {28'd0, acc_d}, 32'd1);
      drive(0, 1, 0, 0, 3'b000, 2'b00);
      chk("dec_down", {28'd0, acc_d}, 32'd0);

      // fd+bk on the toggling edge use the pre-toggle weight
      drive(0, 0, 1, 0, 3'b000, 2'b00);
      for (int k = 0; k < 7; k++) drive(0, 1, 0, 0, 3'b001, 2'b01);
      drive(1, 1, 0, 0, 3'b011, 2'b10);
      chk("tog_fout", {30'd0, fout}, 32'h3);
      chk("tog_bout", {29'd0, bout}, 32'h2);
      chk("tog_ctrl", {31'd0, ctl}, 32'd1);

      for (int k = 0; k < 60; k++)
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));

      drive(0, 0, 1, 1, 3'b000, 2'b00);
      for (int k = 0; k < 5; k++) drive(0, 1, 0, 0, 3'b001, 2'b01);
      chk("pre_rst_acc5", {28'd0, acc}, 32'd5);
      @(negedge clk_in);
      #2;
      mon_en = 1'b0;
      rst_in = 1'b0;
      #1;
      chk("mid_rst_acc", {28'd0, acc}, 32'd0);
      chk("mid_rst_ctrl", {31'd0, ctl}, 32'd0);
      chk("mid_rst_fout", {30'd0, fout}, 32'd0);
      chk("mid_rst_bout", {29'd0, bout}, 32'd0);
      chk("mid_rst_bv", {31'd0, bvalid}, 32'd0);
      fd_prop = 1'b1; bk_prop = 1'b1; fin = 3'b001; bin = 2'b01;
      @(posedge clk_in);
      #1;
      chk("mid_rst_strobe", {31'd0, bvalid}, 32'd0);
      @(negedge clk_in);
      fd_prop = 1'b0; bk_prop = 1'b0;
      rst_in = 1'b1;
      ma[0] = 4'd0; ma[1] = 4'd0; mc[0] = 1'b0; mc[1] = 1'b0;
      fq.delete();
      bq.delete();
      mon_en = 1'b1;
      drive(0, 1, 0, 0, 3'b001, 2'b01);
      chk("post_rst_acc", {28'd0, acc}, 32'd1);

      drive(0, 0, 0, 0, 3'b000, 2'b00);
      drive(0, 0, 0, 0, 3'b000, 2'b00);
      chk("fq_empty", fq.size(), 32'd0);
      chk("bq_empty", bq.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
